// File: rtl/credit_queue_mc_if.sv
// Credit-queue bus interface: incoming credit handshake plus the arbitrated
// output port. The queue itself uses the slave modport; the credit source /
// consumer side uses the master modport.
interface credit_queue_mc_if #(
    parameter int LOG_NCH      = 1,
    parameter int CREDIT_WIDTH = 24,
    parameter int FQID_WIDTH   = 5
);
    localparam int NCH = 1 << LOG_NCH;

    logic                    credit_in_valid;
    logic [CREDIT_WIDTH-1:0] credit_in;
    logic [LOG_NCH-1:0]      credit_in_ch;
    logic [FQID_WIDTH-1:0]   credit_in_nexthop;
    logic                    credit_ack;
    logic [NCH-1:0]          credit_full;
    logic [CREDIT_WIDTH-1:0] credit_out;
    logic [LOG_NCH-1:0]      credit_out_ch;
    logic                    credit_out_valid;
    logic                    credit_dequeue;

    modport master (
        output credit_in_valid, credit_in, credit_in_ch, credit_in_nexthop, credit_dequeue,
        input  credit_ack, credit_full, credit_out, credit_out_ch, credit_out_valid
    );

    modport slave (
        input  credit_in_valid, credit_in, credit_in_ch, credit_in_nexthop, credit_dequeue,
        output credit_ack, credit_full, credit_out, credit_out_ch, credit_out_valid
    );
endinterface

// File: rtl/credit_queue_mc.sv
// Multi-channel credit queue. Incoming credits addressed to this input unit
// are timestamp-shifted by the link latency and stored in one of NCH
// per-channel circular buffers. A single output port releases credits
// round-robin among channels whose head timestamp has matured against
// sim_time (modular, wrap-aware compare).
// Optional build macro: CREDIT_QUEUE_STATS_EN adds a saturating 16-bit
// refused-credit counter on stat_overflow_count (tied to 0 otherwise).
// Assumes CREDIT_WIDTH >= TS_WIDTH and LOG_NCH >= 1.
module credit_queue_mc #(
    parameter int HADDR        = 1,
    parameter int LOG_NCH      = 1,
    parameter int LOG_DEP      = 5,
    parameter int CREDIT_WIDTH = 24,
    parameter int TS_WIDTH     = 16,
    parameter int LAT_WIDTH    = 8,
    parameter int FQID_WIDTH   = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [TS_WIDTH-1:0]  sim_time,
    input  logic [LAT_WIDTH-1:0] latency,
    credit_queue_mc_if.slave     cq,
    output logic                 is_quiescent,
    output logic                 error,
    output logic [15:0]          stat_overflow_count
);
    localparam int NCH = 1 << LOG_NCH;
    localparam int DEP = 1 << LOG_DEP;
    localparam logic [31:0] HADDR_BITS = 32'(HADDR);
    localparam logic [LOG_DEP:0] DEP_CNT = {1'b1, {LOG_DEP{1'b0}}};

    logic [CREDIT_WIDTH-1:0] mem [NCH][DEP];
    logic [LOG_DEP-1:0]      wr_ptr [NCH];
    logic [LOG_DEP-1:0]      rd_ptr [NCH];
    logic [LOG_DEP:0]        count [NCH];
    logic [LOG_NCH-1:0]      rr_last;

    logic [NCH-1:0]          full_vec;
    logic [NCH-1:0]          mature;
    logic [NCH-1:0]          push_vec;
    logic [NCH-1:0]          pop_vec;
    logic [TS_WIDTH-1:0]     age;
    logic [LOG_NCH-1:0]      sel;
    logic [LOG_NCH-1:0]      idx;
    logic                    found;
    logic                    any_mature;
    logic                    match;
    logic                    ack;
    logic                    refused;
    logic                    do_deq;
    logic                    bad_deq;
    logic [CREDIT_WIDTH-1:0] word_in;

    assign match   = (cq.credit_in_nexthop == HADDR_BITS[FQID_WIDTH-1:0]);
    assign ack     = enable & cq.credit_in_valid & match & ~full_vec[cq.credit_in_ch];
    assign refused = enable & cq.credit_in_valid & match & full_vec[cq.credit_in_ch];
    assign do_deq  = enable & cq.credit_dequeue & any_mature;
    assign bad_deq = enable & cq.credit_dequeue & ~any_mature;

    // Per-channel full flag and head maturity: the head is mature once
    // sim_time - head_ts is non-negative in modular arithmetic.
    always_comb begin
        full_vec = '0;
        mature   = '0;
        age      = '0;
        for (int c = 0; c < NCH; c++) begin
            full_vec[c] = (count[c] == DEP_CNT);
            age         = sim_time - mem[c][rd_ptr[c]][TS_WIDTH-1:0];
            mature[c]   = (count[c] != '0) && !age[TS_WIDTH-1];
        end
    end

    // Round-robin pick: first mature channel strictly after rr_last, with wrap;
    // the last slot scanned is rr_last itself.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NCH; i++) begin
            idx = rr_last + LOG_NCH'(i);
            if (!found && mature[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        any_mature = found;
    end

    // Incoming word with its timestamp field advanced by the link latency.
    always_comb begin
        word_in                 = cq.credit_in;
        word_in[TS_WIDTH-1:0]   = cq.credit_in[TS_WIDTH-1:0] + TS_WIDTH'(latency);
    end

    // One-hot push/pop strobes per channel.
    always_comb begin
        push_vec = '0;
        pop_vec  = '0;
        if (ack)    push_vec[cq.credit_in_ch] = 1'b1;
        if (do_deq) pop_vec[sel]              = 1'b1;
    end

    // Pointer, occupancy, arbitration and sticky error state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NCH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
            rr_last <= '1;
            error   <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (push_vec[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
                if (pop_vec[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
                case ({push_vec[c], pop_vec[c]})
                    2'b10:   count[c] <= count[c] + 1'b1;
                    2'b01:   count[c] <= count[c] - 1'b1;
                    default: count[c] <= count[c];
                endcase
            end
            if (do_deq) rr_last <= sel;
            if (refused || bad_deq) error <= 1'b1;
        end
    end

    // Credit storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clock) begin
        if (ack) mem[cq.credit_in_ch][wr_ptr[cq.credit_in_ch]] <= word_in;
    end

    // All channels empty.
    always_comb begin
        is_quiescent = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            if (count[c] != '0) is_quiescent = 1'b0;
        end
    end

    assign cq.credit_ack       = ack;
    assign cq.credit_full      = full_vec;
    assign cq.credit_out       = mem[sel][rd_ptr[sel]];
    assign cq.credit_out_ch    = sel;
    assign cq.credit_out_valid = any_mature;

`ifdef CREDIT_QUEUE_STATS_EN
    logic [15:0] ovf_cnt;

    // Saturating count of credits refused because their channel was full.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf_cnt <= '0;
        end else if (refused && ovf_cnt != 16'hFFFF) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end

    assign stat_overflow_count = ovf_cnt;
`else
    assign stat_overflow_count = 16'h0000;
`endif
endmodule

// File: tb/tb_credit_queue_mc.sv
// Directed bench for credit_queue_mc: a vector table for single-cycle
// behaviour, plus hand-written sequences for reset, fill/overflow and
// pointer wrap.
module tb_credit_queue_mc;
    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] sim_time;
    logic [7:0]  latency;
    logic        is_quiescent;
    logic        error;
    logic [15:0] stat_overflow_count;

    int total = 0;
    int bad   = 0;

    credit_queue_mc_if #(.LOG_NCH(1), .CREDIT_WIDTH(24), .FQID_WIDTH(5)) cq_if ();

    credit_queue_mc #(
        .HADDR(1), .LOG_NCH(1), .LOG_DEP(5), .CREDIT_WIDTH(24),
        .TS_WIDTH(16), .LAT_WIDTH(8), .FQID_WIDTH(5)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .enable              (enable),
        .sim_time            (sim_time),
        .latency             (latency),
        .cq                  (cq_if),
        .is_quiescent        (is_quiescent),
        .error               (error),
        .stat_overflow_count (stat_overflow_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        en;
        logic [15:0] st;
        logic [7:0]  lat;
        logic        v;
        logic [23:0] cr;
        logic        ch;
        logic [4:0]  nh;
        logic        dq;
        logic        ack;
        logic        ov;
        logic        och;
        logic [23:0] oc;
        logic        q;
        logic        err;
        logic [1:0]  full;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic en, input logic [15:0] st, input logic [7:0] lat,
                         input logic v, input logic [23:0] cr, input logic ch,
                         input logic [4:0] nh, input logic dq);
        enable                  = en;
        sim_time                = st;
        latency                 = lat;
        cq_if.credit_in_valid   = v;
        cq_if.credit_in         = cr;
        cq_if.credit_in_ch      = ch;
        cq_if.credit_in_nexthop = nh;
        cq_if.credit_dequeue    = dq;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    logic [15:0] exp_stat;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //     en    st        lat    v     cr          ch    nh     dq   | ack   ov    och   oc          q     err   full
        tbl.push_back('{1'b1, 16'h0012, 8'd4, 1'b1, 24'hA50010, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 2'b00});
        tbl.push_back('{1'b1, 16'h0012, 8'd4, 1'b0, 24'h000000, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 2'b00});
        tbl.push_back('{1'b1, 16'h0013, 8'd4, 1'b0, 24'h000000, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 2'b00});
        tbl.push_back('{1'b1, 16'h0014, 8'd4, 1'b0, 24'h000000, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 24'hA50014, 1'b0, 1'b0, 2'b00});
        tbl.push_back('{1'b1, 16'h0014, 8'd4, 1'b1, 24'hBB0099, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 24'hA50014, 1'b0, 1'b0, 2'b00});
        tbl.push_back('{1'b1, 16'h0014, 8'd4, 1'b0, 24'h000000, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 24'hA50014, 1'b0, 1'b0, 2'b00});
        tbl.push_back('{1'b1, 16'h0014, 8'd4, 1'b1, 24'hCC0001, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 2'b00});
        tbl.push_back('{1'b1, 16'h0014, 8'd0, 1'b1, 24'h010020, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 2'b00});
        tbl.push_back('{1'b1, 16'h0014, 8'd0, 1'b1, 24'h020021, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 2'b00});
        tbl.push_back('{1'b1, 16'h0014, 8'd0, 1'b1, 24'h030022, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 2'b00});
        tbl.push_back('{1'b1, 16'h0014, 8'd0, 1'b1, 24'h040023, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 2'b00});
        tbl.push_back('{1'b1, 16'h0030, 8'd0, 1'b0, 24'h000000, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1, 24'h020021, 1'b0, 1'b0, 2'b00});
        tbl.push_back('{1'b1, 16'h0030, 8'd0, 1'b0, 24'h000000, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h010020, 1'b0, 1'b0, 2'b00});
        tbl.push_back('{1'b1, 16'h0030, 8'd0, 1'b0, 24'h000000, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1, 24'h040023, 1'b0, 1'b0, 2'b00});
        tbl.push_back('{1'b1, 16'h0030, 8'd0, 1'b0, 24'h000000, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h030022, 1'b0, 1'b0, 2'b00});
        tbl.push_back('{1'b0, 16'h0030, 8'd0, 1'b1, 24'h050040, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 2'b00});
        tbl.push_back('{1'b1, 16'h0030, 8'd0, 1'b0, 24'h000000, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 2'b00});
        tbl.push_back('{1'b1, 16'hFFF0, 8'd8, 1'b1, 24'h06FFF0, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 2'b00});
        tbl.push_back('{1'b1, 16'hFFF0, 8'd8, 1'b0, 24'h000000, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 2'b00});
        tbl.push_back('{1'b1, 16'h0002, 8'd8, 1'b0, 24'h000000, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 24'h06FFF8, 1'b0, 1'b0, 2'b00});
        tbl.push_back('{1'b1, 16'h0002, 8'd8, 1'b0, 24'h000000, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h06FFF8, 1'b0, 1'b0, 2'b00});
        tbl.push_back('{1'b1, 16'h0002, 8'd0, 1'b0, 24'h000000, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 2'b00});
        tbl.push_back('{1'b1, 16'h0002, 8'd0, 1'b1, 24'h070001, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 2'b00});
        tbl.push_back('{1'b1, 16'h0002, 8'd0, 1'b1, 24'h080002, 1'b0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 24'h070001, 1'b0, 1'b0, 2'b00});
        tbl.push_back('{1'b1, 16'h0002, 8'd0, 1'b0, 24'h000000, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 24'h080002, 1'b0, 1'b0, 2'b00});
        tbl.push_back('{1'b1, 16'h0002, 8'd0, 1'b0, 24'h000000, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h080002, 1'b0, 1'b0, 2'b00});
        tbl.push_back('{1'b1, 16'h0002, 8'd0, 1'b0, 24'h000000, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 2'b00});
        tbl.push_back('{1'b1, 16'h0002, 8'd0, 1'b0, 24'h000000, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 2'b00});
        tbl.push_back('{1'b1, 16'h0002, 8'd0, 1'b0, 24'h000000, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 2'b00});

        // Reset state
        reset = 1'b0;
        drive(1'b0, 16'h0000, 8'd0, 1'b0, 24'h0, 1'b0, 5'd0, 1'b0);
        #12;
        chk("rst_quiescent", 32'(is_quiescent), 32'd1);
        chk("rst_error",     32'(error), 32'd0);
        chk("rst_full",      32'(cq_if.credit_full), 32'd0);
        chk("rst_out_valid", 32'(cq_if.credit_out_valid), 32'd0);
        chk("rst_out_ch",    32'(cq_if.credit_out_ch), 32'd0);
        chk("rst_ack",       32'(cq_if.credit_ack), 32'd0);
        chk("rst_stat",      32'(stat_overflow_count), 32'd0);
        reset = 1'b1;
        next_cycle();

        // Vector table
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t r;
            r = tbl[i];
            drive(r.en, r.st, r.lat, r.v, r.cr, r.ch, r.nh, r.dq);
            @(negedge clock);
            chk($sformatf("v%0d_ack", i),   32'(cq_if.credit_ack), 32'(r.ack));
            chk($sformatf("v%0d_ov", i),    32'(cq_if.credit_out_valid), 32'(r.ov));
            chk($sformatf("v%0d_och", i),   32'(cq_if.credit_out_ch), 32'(r.och));
            if (r.ov) chk($sformatf("v%0d_out", i), 32'(cq_if.credit_out), 32'(r.oc));
            chk($sformatf("v%0d_q", i),     32'(is_quiescent), 32'(r.q));
            chk($sformatf("v%0d_err", i),   32'(error), 32'(r.err));
            chk($sformatf("v%0d_full", i),  32'(cq_if.credit_full), 32'(r.full));
            next_cycle();
        end

        // Reset asserted mid-stream with a credit stored and error set
        drive(1'b1, 16'h0000, 8'd0, 1'b1, 24'h090500, 1'b1, 5'd1, 1'b0);
        @(negedge clock);
        chk("mid_ack", 32'(cq_if.credit_ack), 32'd1);
        next_cycle();
        drive(1'b1, 16'h0000, 8'd0, 1'b0, 24'h0, 1'b0, 5'd1, 1'b0);
        #1;
        chk("mid_pre_q", 32'(is_quiescent), 32'd0);
        chk("mid_pre_err", 32'(error), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_q",    32'(is_quiescent), 32'd1);
        chk("mid_rst_err",  32'(error), 32'd0);
        chk("mid_rst_ov",   32'(cq_if.credit_out_valid), 32'd0);
        chk("mid_rst_och",  32'(cq_if.credit_out_ch), 32'd0);
        chk("mid_rst_full", 32'(cq_if.credit_full), 32'd0);
        chk("mid_rst_ack",  32'(cq_if.credit_ack), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        next_cycle();

        // Fill channel 1 with DEP credits (timestamps in the future)
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 16'h0000, 8'd0, 1'b1, {8'(i), 16'(16'h0100 + i)}, 1'b1, 5'd1, 1'b0);
            @(negedge clock);
            chk($sformatf("fill%0d_ack", i), 32'(cq_if.credit_ack), 32'd1);
            next_cycle();
        end
        drive(1'b1, 16'h0000, 8'd0, 1'b0, 24'h0, 1'b0, 5'd1, 1'b0);
        #1;
        chk("fill_full", 32'(cq_if.credit_full), 32'd2);
        chk("fill_err",  32'(error), 32'd0);
        chk("fill_ov",   32'(cq_if.credit_out_valid), 32'd0);

        // 33rd credit refused
        drive(1'b1, 16'h0000, 8'd0, 1'b1, 24'hC00200, 1'b1, 5'd1, 1'b0);
        @(negedge clock);
        chk("ovf_ack", 32'(cq_if.credit_ack), 32'd0);
        next_cycle();
        chk("ovf_err", 32'(error), 32'd1);
`ifdef CREDIT_QUEUE_STATS_EN
        exp_stat = 16'd1;
`else
        exp_stat = 16'd0;
`endif
        chk("ovf_stat1", 32'(stat_overflow_count), 32'(exp_stat));

        // Still refused while the same channel dequeues this cycle
        drive(1'b1, 16'h0200, 8'd0, 1'b1, 24'hC10201, 1'b1, 5'd1, 1'b1);
        @(negedge clock);
        chk("ovfdq_ack", 32'(cq_if.credit_ack), 32'd0);
        chk("ovfdq_ov",  32'(cq_if.credit_out_valid), 32'd1);
        chk("ovfdq_och", 32'(cq_if.credit_out_ch), 32'd1);
        chk("ovfdq_out", 32'(cq_if.credit_out), 32'h000100);
        next_cycle();
        chk("ovfdq_full", 32'(cq_if.credit_full), 32'd0);
`ifdef CREDIT_QUEUE_STATS_EN
        exp_stat = 16'd2;
`else
        exp_stat = 16'd0;
`endif
        chk("ovf_stat2", 32'(stat_overflow_count), 32'(exp_stat));

        // Enqueue into the wrapped write slot, then drain in FIFO order
        drive(1'b1, 16'h0200, 8'd0, 1'b1, 24'hE00150, 1'b1, 5'd1, 1'b0);
        @(negedge clock);
        chk("wrap_ack", 32'(cq_if.credit_ack), 32'd1);
        next_cycle();
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 16'h0200, 8'd0, 1'b0, 24'h0, 1'b0, 5'd1, 1'b1);
            @(negedge clock);
            chk($sformatf("drain%0d_och", i), 32'(cq_if.credit_out_ch), 32'd1);
            chk($sformatf("drain%0d_out", i), 32'(cq_if.credit_out), 32'({8'(i), 16'(16'h0100 + i)}));
            next_cycle();
        end
        drive(1'b1, 16'h0200, 8'd0, 1'b0, 24'h0, 1'b0, 5'd1, 1'b1);
        @(negedge clock);
        chk("wrap_ov",  32'(cq_if.credit_out_valid), 32'd1);
        chk("wrap_out", 32'(cq_if.credit_out), 32'h00E00150);
        next_cycle();
        drive(1'b1, 16'h0200, 8'd0, 1'b0, 24'h0, 1'b0, 5'd1, 1'b0);
        #1;
        chk("wrap_q",  32'(is_quiescent), 32'd1);
        chk("wrap_ov_end", 32'(cq_if.credit_out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/credit_queue_mc.md
Name: credit_queue_mc

Overview:
- Multi-channel credit queue; parametrised successor to the single 32-deep credit FIFO inside a router input unit.
- Accepts timestamped credits addressed to this input unit and steers each into one of NCH per-VC circular buffers, adding link latency to the timestamp.
- Releases credits through one output port: round-robin among channels whose head timestamp has matured against sim_time (wrap-aware).

Parameters:
- HADDR, 1: global node ID plus port ID; low FQID_WIDTH bits are matched against credit_in_nexthop.
- LOG_NCH, 1: log2 of channel count; NCH = 1 << LOG_NCH.
- LOG_DEP, 5: log2 of per-channel depth; DEP = 1 << LOG_DEP.
- CREDIT_WIDTH, 24: credit word width; timestamp occupies bits [TS_WIDTH-1:0].
- TS_WIDTH, 16: timestamp / sim_time width.
- LAT_WIDTH, 8: latency width.
- FQID_WIDTH, 5: nexthop ID width.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  global advance; when 0, no enqueue or dequeue takes effect.
- sim_time  in  TS_WIDTH  current simulation time.
- latency  in  LAT_WIDTH  added to every incoming timestamp.
- credit_in_valid  in  1  incoming credit valid.
- credit_in  in  CREDIT_WIDTH  incoming credit.
- credit_in_ch  in  LOG_NCH  target channel.
- credit_in_nexthop  in  FQID_WIDTH  destination ID.
- credit_ack  out  1  credit accepted this cycle.
- credit_full  out  NCH  per-channel full.
- credit_out  out  CREDIT_WIDTH  head of the selected channel.
- credit_out_ch  out  LOG_NCH  selected channel.
- credit_out_valid  out  1  selected head is mature.
- credit_dequeue  in  1  pop the selected head.
- is_quiescent  out  1  all channels empty.
- error  out  1  sticky error flag.
- stat_overflow_count  out  16  refused-credit counter (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous): all pointers and counts 0; rr_last = NCH-1; error=0.
  - Outputs after reset: credit_full=0, credit_out_valid=0, credit_out_ch=0, is_quiescent=1, credit_ack=0.
- Match: match = (credit_in_nexthop == HADDR[FQID_WIDTH-1:0]).
- Acceptance: credit_ack = enable & credit_in_valid & match & ~credit_full[credit_in_ch]. Combinational.
  - Accepted word = credit_in with ts field replaced by (ts + latency) mod 2^TS_WIDTH; other bits unchanged.
- Storage: per-channel count is LOG_DEP+1 bits, so full means count == DEP and empty means count == 0. Read and write pointers wrap mod DEP.
- Maturity: per channel, mature = (count != 0) & ((sim_time - head_ts) MSB == 0).
  - Modular compare: a head ts 0xFFF0 is mature at sim_time 0x0005.
- Arbitration: selection = the first mature channel strictly after rr_last, scanning upward with wrap.
  - credit_out_valid = any mature channel.
  - credit_out and credit_out_ch are combinational from the selection. credit_out_ch=0 when none is mature.
- Dequeue: credit_dequeue & enable & credit_out_valid pops the selected channel and sets rr_last to that channel.
- Latency: a credit accepted at edge N is visible and eligible from cycle N+1. Minimum residency is 1 cycle.
- Boundary conditions:
  - Same-cycle enqueue and dequeue on one channel: both occur; count unchanged.
  - Full channel: enqueue refused even if a dequeue on that channel happens the same cycle.
  - Depth wrap: after DEP enqueues and DEP dequeues, pointers return to 0 and FIFO order is preserved.
  - enable=0: no state change; acks are 0; outputs still track sim_time.
- Error (sticky until reset):
  - set on credit_in_valid & match & credit_full[credit_in_ch] & enable;
  - set on credit_dequeue & enable & ~credit_out_valid; that dequeue is ignored.
- Reset mid-operation: all stored credits discarded; outputs return to reset values immediately.

Optional Feature:
- Macro: CREDIT_QUEUE_STATS_EN.
- Defined: 16-bit counter increments on each refused credit (valid & match & full & enable). It saturates at 0xFFFF and clears on reset.
- Undefined: stat_overflow_count tied to 0; no counter logic.

Test Plan:
- Single credit, ch0, ts=0x0010, latency=4, sim_time=0x0012 → ack=1; credit_out_valid stays 0 until sim_time=0x0014, then credit_out ts=0x0014, credit_out_ch=0.
- Nexthop mismatch with valid=1 → ack=0, is_quiescent stays 1, error stays 0.
- Fill ch1 with 32 credits, then send a 33rd → credit_full[1]=1, ack=0, error=1; with STATS_EN, stat_overflow_count=1.
- ch0 and ch1 both mature, dequeue every cycle → credit_out_ch alternates 0,1,0,1; each channel is in FIFO order.
- Head ts=0xFFF8 (0xFFF0 + latency 8), sim_time wraps to 0x0002 → credit_out_valid=1.
- Dequeue while nothing is mature → error=1, counts unchanged. Assert reset mid-stream → is_quiescent=1, error=0.
